// File: rtl/usb_in_sched_if.sv
// Signal bundle between the IN scheduler, firmware, byte memory and IN FIFO.
// Handshake semantics: there is no valid/ready pair here. start, abort,
// in_sent, zlp_set, done, fifo_sclr, mem_rd and fifo_wrreq are single-cycle
// strobes that take effect on the rising clk edge where they are high.
// mem_q is valid exactly one cycle after mem_rd. fifo_empty is a level.
// The slave modport is the scheduler; the master modport is its environment.
interface usb_in_sched_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [15:0]       desc_len;
    logic [15:0]       req_len;
    logic              abort;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_q;
    logic              fifo_wrreq;
    logic [7:0]        fifo_data;
    logic              fifo_empty;
    logic              fifo_sclr;
    logic              zlp_set;
    logic              in_sent;
    logic              busy;
    logic              done;
    logic [15:0]       byte_cnt;
    logic [2:0]        dbg_state;

    modport slave (
        input  start, base_addr, desc_len, req_len, abort, mem_q,
               fifo_empty, in_sent,
        output mem_rd, mem_addr, fifo_wrreq, fifo_data, fifo_sclr,
               zlp_set, busy, done, byte_cnt, dbg_state
    );

    modport master (
        output start, base_addr, desc_len, req_len, abort, mem_q,
               fifo_empty, in_sent,
        input  mem_rd, mem_addr, fifo_wrreq, fifo_data, fifo_sclr,
               zlp_set, busy, done, byte_cnt, dbg_state
    );
endinterface

// File: rtl/usb_in_sched.sv
// IN endpoint scheduler: streams a byte buffer into the IN FIFO as a series
// of max-packet packets, clamps to the host-requested length and arms a
// zero-length packet when the transfer ends on a packet boundary short of
// the requested length.
module usb_in_sched #(
    parameter int MAX_PKT = 8,
    parameter int ADDR_W  = 8
) (
    input  logic          clk,
    input  logic          reset,
    usb_in_sched_if.slave io_bus
);
    localparam int PKT_BITS = $clog2(MAX_PKT);
    localparam int CHUNK_W  = PKT_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_EMPTY,
        S_RD,
        S_WR,
        S_WAIT_SENT,
        S_ZLP,
        S_WAIT_ZLP,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_remaining;
    logic [15:0]         r_byte_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [CHUNK_W-1:0]  r_chunk;
    logic                r_need_zlp;
    logic                r_sclr;

    logic [15:0]         w_xfer_len;
    logic                w_need_zlp;
    logic [CHUNK_W-1:0]  w_chunk_init;
    logic                w_abort;
    logic                w_load;
    logic                w_chunk_load;
    logic                w_wr_step;
    logic                w_mem_rd;
    logic                w_fifo_wr;
    logic                w_zlp;
    logic                w_done;

    // abort only means something while a transfer is in flight
    assign w_abort    = io_bus.abort && (r_state != S_IDLE);
    assign w_xfer_len = (io_bus.desc_len < io_bus.req_len) ? io_bus.desc_len : io_bus.req_len;
    // a short transfer ending exactly on a packet boundary (including zero
    // bytes) needs a ZLP so the host sees the end of the data stage
    assign w_need_zlp = (w_xfer_len < io_bus.req_len) && (w_xfer_len[PKT_BITS-1:0] == '0);
    assign w_chunk_init = (r_remaining >= 16'(MAX_PKT)) ? CHUNK_W'(MAX_PKT)
                                                        : r_remaining[CHUNK_W-1:0];

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state logic and per-state strobes; abort overrides every transition
    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_chunk_load = 1'b0;
        w_wr_step    = 1'b0;
        w_mem_rd     = 1'b0;
        w_fifo_wr    = 1'b0;
        w_zlp        = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_load = 1'b1;
                    w_next = (w_xfer_len != 16'd0) ? S_WAIT_EMPTY : S_ZLP;
                end
            end
            S_WAIT_EMPTY: begin
                if (io_bus.fifo_empty) begin
                    w_chunk_load = 1'b1;
                    w_next       = S_RD;
                end
            end
            S_RD: begin
                w_mem_rd = 1'b1;
                w_next   = S_WR;
            end
            S_WR: begin
                w_fifo_wr = 1'b1;
                w_wr_step = 1'b1;
                w_next    = (r_chunk == CHUNK_W'(1)) ? S_WAIT_SENT : S_RD;
            end
            S_WAIT_SENT: begin
                if (io_bus.in_sent) begin
                    if (r_remaining != 16'd0) begin
                        w_next = S_WAIT_EMPTY;
                    end else if (r_need_zlp) begin
                        w_next = S_ZLP;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_ZLP: begin
                w_zlp  = 1'b1;
                w_next = S_WAIT_ZLP;
            end
            S_WAIT_ZLP: begin
                if (io_bus.in_sent) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_abort) begin
            w_next       = S_IDLE;
            w_load       = 1'b0;
            w_chunk_load = 1'b0;
            w_wr_step    = 1'b0;
        end
    end

    // transfer bookkeeping: address, remaining bytes, packet chunk, byte count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_remaining <= '0;
            r_byte_cnt  <= '0;
            r_addr      <= '0;
            r_chunk     <= '0;
            r_need_zlp  <= 1'b0;
            r_sclr      <= 1'b0;
        end else begin
            r_sclr <= w_abort;
            if (w_load) begin
                r_remaining <= w_xfer_len;
                r_addr      <= io_bus.base_addr;
                r_byte_cnt  <= '0;
                r_need_zlp  <= w_need_zlp;
            end
            if (w_chunk_load) begin
                r_chunk <= w_chunk_init;
            end
            if (w_wr_step) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 16'd1;
                r_byte_cnt  <= r_byte_cnt + 16'd1;
                r_chunk     <= r_chunk - 1'b1;
            end
        end
    end

    assign io_bus.mem_rd     = w_mem_rd;
    assign io_bus.mem_addr   = w_mem_rd ? r_addr : '0;
    assign io_bus.fifo_wrreq = w_fifo_wr;
    assign io_bus.fifo_data  = w_fifo_wr ? io_bus.mem_q : 8'h00;
    assign io_bus.fifo_sclr  = r_sclr;
    assign io_bus.zlp_set    = w_zlp;
    assign io_bus.done       = w_done;
    // busy falls in the same cycle that done pulses
    assign io_bus.busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign io_bus.byte_cnt   = r_byte_cnt;
    assign io_bus.dbg_state  = r_state;
endmodule

// File: tb/tb_usb_in_sched.sv
// Directed bench for usb_in_sched: a synchronous memory model, a FIFO level
// model, and a scoreboard of expected read addresses and FIFO bytes.
module tb_usb_in_sched;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  usb_in_sched_if #(.ADDR_W(8)) bus ();

  usb_in_sched #(.MAX_PKT(8), .ADDR_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  logic [7:0] mem [256];
  logic [7:0] mem_q_r;
  logic [7:0] exp_q[$];
  logic [7:0] addr_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int level = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int zlp_cnt = 0;
  int done_cnt = 0;
  logic take = 1'b0;

  // synchronous byte memory: data one cycle after the read strobe
  always @(posedge clk) begin
    if (bus.mem_rd) mem_q_r <= mem[bus.mem_addr];
  end
  assign bus.mem_q = mem_q_r;
  assign bus.fifo_empty = (level == 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // scoreboard / FIFO model, sampled on the falling edge
  always @(negedge clk) begin
    if ((bus.in_sent && take) || bus.fifo_sclr || reset) level = 0;
    if (bus.mem_rd) begin
      rd_cnt++;
      if (addr_q.size() == 0) check("rd_unexpected", 1, 0);
      else check("mem_addr", bus.mem_addr, addr_q.pop_front());
    end
    if (bus.fifo_wrreq) begin
      wr_cnt++;
      level++;
      if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
      else check("fifo_data", bus.fifo_data, exp_q.pop_front());
      check("fifo_overflow", level > 8, 0);
    end
    if (bus.zlp_set) zlp_cnt++;
    if (bus.done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] base, input logic [15:0] dl, input logic [15:0] rl);
    logic [15:0] x;
    x = (dl < rl) ? dl : rl;
    for (int i = 0; i < int'(x); i++) begin
      logic [7:0] a;
      a = base + 8'(i);
      addr_q.push_back(a);
      exp_q.push_back(mem[a]);
    end
    bus.base_addr = base;
    bus.desc_len = dl;
    bus.req_len = rl;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_in_sent();
    take = 1'b1;
    bus.in_sent = 1'b1;
    tick();
    bus.in_sent = 1'b0;
    take = 1'b0;
  endtask

  task automatic wait_pkt(input string tag, input int n);
    int k;
    k = 0;
    while (level < n && k < 200) begin
      tick();
      k++;
    end
    repeat (4) tick();
    check(tag, level, n);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!bus.done && k < 50) begin
      tick();
      k++;
    end
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_busy_low"}, bus.busy, 0);
    tick();
    check({tag, "_q_empty"}, exp_q.size() + addr_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int z0, d0, r0, w0, k;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.in_sent = 1'b0;
    bus.base_addr = '0;
    bus.desc_len = '0;
    bus.req_len = '0;

    // reset state
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_mem_rd", bus.mem_rd, 0);
    check("rst_fifo_wrreq", bus.fifo_wrreq, 0);
    check("rst_fifo_sclr", bus.fifo_sclr, 0);
    check("rst_zlp_set", bus.zlp_set, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_fifo_data", bus.fifo_data, 0);
    check("rst_byte_cnt", bus.byte_cnt, 0);

    // abort in IDLE is ignored
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("idle_abort_sclr", bus.fifo_sclr, 0);

    // 18 of 64 bytes: 8, 8, 2, no ZLP
    z0 = zlp_cnt;
    do_start(8'h20, 16'd18, 16'd64);
    check("t1_busy", bus.busy, 1);
    wait_pkt("t1_pkt0", 8);
    send_in_sent();
    wait_pkt("t1_pkt1", 8);
    send_in_sent();
    wait_pkt("t1_pkt2", 2);
    check("t1_no_early_done", done_cnt, 0);
    send_in_sent();
    wait_done("t1");
    check("t1_no_zlp", zlp_cnt, z0);
    check("t1_byte_cnt", bus.byte_cnt, 18);

    // 16 of 64 bytes: boundary ending needs a ZLP
    d0 = done_cnt;
    do_start(8'h00, 16'd16, 16'd64);
    wait_pkt("t2_pkt0", 8);
    send_in_sent();
    wait_pkt("t2_pkt1", 8);
    send_in_sent();
    k = 0;
    while (!bus.zlp_set && k < 20) begin
      tick();
      k++;
    end
    check("t2_zlp_set", bus.zlp_set, 1);
    repeat (3) tick();
    check("t2_no_done_before_sent", done_cnt, d0);
    check("t2_busy_waiting", bus.busy, 1);
    send_in_sent();
    wait_done("t2");
    check("t2_byte_cnt", bus.byte_cnt, 16);

    // clamped to req_len: 16 bytes, no ZLP
    z0 = zlp_cnt;
    do_start(8'h80, 16'd40, 16'd16);
    wait_pkt("t3_pkt0", 8);
    send_in_sent();
    wait_pkt("t3_pkt1", 8);
    send_in_sent();
    wait_done("t3");
    check("t3_no_zlp", zlp_cnt, z0);
    check("t3_byte_cnt", bus.byte_cnt, 16);

    // empty descriptor: immediate ZLP
    r0 = rd_cnt;
    w0 = wr_cnt;
    do_start(8'h00, 16'd0, 16'd8);
    check("t4_zlp_next_cycle", bus.zlp_set, 1);
    check("t4_busy", bus.busy, 1);
    tick();
    check("t4_zlp_one_cycle", bus.zlp_set, 0);
    send_in_sent();
    wait_done("t4");
    check("t4_no_rd", rd_cnt, r0);
    check("t4_no_wr", wr_cnt, w0);
    check("t4_byte_cnt", bus.byte_cnt, 0);

    // abort during the 5th write of the first packet
    d0 = done_cnt;
    z0 = zlp_cnt;
    do_start(8'h40, 16'd18, 16'd64);
    k = 0;
    while (!(bus.fifo_wrreq && level == 4) && k < 100) begin
      tick();
      k++;
    end
    check("t5_at_5th_wr", bus.fifo_wrreq, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t5_sclr", bus.fifo_sclr, 1);
    check("t5_busy_low", bus.busy, 0);
    exp_q.delete();
    addr_q.delete();
    r0 = rd_cnt;
    tick();
    check("t5_sclr_one_cycle", bus.fifo_sclr, 0);
    repeat (10) tick();
    check("t5_no_more_rd", rd_cnt, r0);
    check("t5_no_done", done_cnt, d0);
    check("t5_no_zlp", zlp_cnt, z0);

    // clean restart; a start while busy is ignored
    do_start(8'h50, 16'd10, 16'd64);
    bus.base_addr = 8'h99;
    bus.desc_len = 16'd3;
    bus.req_len = 16'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_pkt("t5b_pkt0", 8);
    send_in_sent();
    wait_pkt("t5b_pkt1", 2);
    send_in_sent();
    wait_done("t5b");
    check("t5b_byte_cnt", bus.byte_cnt, 10);
    check("t5b_no_zlp", zlp_cnt, z0);

    // address wrap with a stray in_sent during RD/WR
    do_start(8'hFC, 16'd8, 16'd64);
    k = 0;
    while (!(bus.mem_rd && level == 2) && k < 100) begin
      tick();
      k++;
    end
    check("t6_stray_at_rd", bus.mem_rd, 1);
    bus.in_sent = 1'b1;
    tick();
    check("t6_stray_at_wr", bus.fifo_wrreq, 1);
    tick();
    bus.in_sent = 1'b0;
    wait_pkt("t6_pkt0", 8);
    check("t6_busy", bus.busy, 1);
    send_in_sent();
    k = 0;
    while (!bus.zlp_set && k < 20) begin
      tick();
      k++;
    end
    check("t6_zlp_set", bus.zlp_set, 1);
    tick();
    send_in_sent();
    wait_done("t6");
    check("t6_byte_cnt", bus.byte_cnt, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/usb_in_sched.md
Name: usb_in_sched

Overview:
- Hardware scheduler for an 8-byte IN endpoint FIFO: streams a byte buffer (e.g. a descriptor ROM) to the host as a sequence of max-packet IN packets.
- Sits between the J1 firmware, a synchronous byte memory and the IN FIFO write port of the serial interface engine.
- Clamps the transfer to the requested length and requests a zero-length packet when USB short-packet rules require one.
- Frees firmware from per-packet FIFO refills during control-read data stages.

Parameters:
- MAX_PKT, 8, endpoint max packet size in bytes (power of 2, 8..64).
- ADDR_W, 8, memory address width.

Ports:
- clk  in  1  24 MHz system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin transfer
- base_addr  in  ADDR_W  first byte address, sampled on start
- desc_len  in  16  bytes available in memory, sampled on start
- req_len  in  16  host-requested length (wLength), sampled on start
- abort  in  1  one-cycle pulse: cancel transfer (new SETUP or bus reset)
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_q  in  8  memory data, valid exactly 1 cycle after mem_rd
- fifo_wrreq  out  1  IN FIFO write strobe
- fifo_data  out  8  IN FIFO write data
- fifo_empty  in  1  IN FIFO empty flag
- fifo_sclr  out  1  IN FIFO synchronous clear
- zlp_set  out  1  one-cycle pulse: arm ZLP on the endpoint
- in_sent  in  1  one-cycle pulse from SIE: IN packet transmission completed
- busy  out  1  high from the cycle after start until done or abort
- done  out  1  one-cycle pulse: transfer complete
- byte_cnt  out  16  bytes handed to the FIFO so far in this transfer

Behaviour:
- Reset: state IDLE. mem_rd, fifo_wrreq, fifo_sclr, zlp_set, busy and done are 0. mem_addr, fifo_data and byte_cnt are 0.
- On start in IDLE:
  - xfer_len = min(desc_len, req_len), 16-bit unsigned compare.
  - remaining = xfer_len; addr = base_addr; byte_cnt = 0.
  - need_zlp = (xfer_len < req_len) && (xfer_len mod MAX_PKT == 0). This includes xfer_len == 0.
  - Next state: WAIT_EMPTY if xfer_len > 0, otherwise ZLP.
- start is ignored while busy.
- States:
  - IDLE: described above.
  - WAIT_EMPTY: stay until fifo_empty == 1. Then chunk = min(remaining, MAX_PKT) and go to RD.
  - RD: mem_rd = 1 and mem_addr = addr for one cycle, then go to WR.
  - WR:
    - fifo_wrreq = 1 and fifo_data = mem_q.
    - addr++ (wraps modulo 2^ADDR_W), remaining--, byte_cnt++, chunk--.
    - If chunk becomes 0, go to WAIT_SENT; otherwise go to RD.
    - Throughput is 1 byte per 2 cycles.
  - WAIT_SENT: on in_sent, go to WAIT_EMPTY if remaining > 0. Otherwise go to ZLP if need_zlp, else DONE.
  - ZLP: zlp_set pulses for 1 cycle, then go to WAIT_ZLP.
  - WAIT_ZLP: on in_sent, go to DONE.
  - DONE: done = 1 for one cycle, then go to IDLE (busy drops in the same cycle as done).
- in_sent is ignored outside WAIT_SENT and WAIT_ZLP.
- abort (any state except IDLE):
  - Next cycle: state IDLE, busy 0, fifo_sclr = 1 for one cycle.
  - No done and no zlp_set.
  - byte_cnt holds its value.
  - abort has priority over a simultaneous in_sent or start.
  - In IDLE, abort is ignored (no fifo_sclr).
- At most MAX_PKT writes occur per FIFO-empty epoch, so the FIFO never overflows and fifo_full is not needed.
- Reset mid-transfer behaves like abort but without fifo_sclr; the SIE clears the FIFO on bus reset.

Test Plan:
- MAX_PKT=8, desc_len=18, req_len=64, base 0x20: packets of 8, 8, 2 bytes from addresses 0x20..0x31 in order, each packet after an in_sent. No zlp_set. done after the 3rd in_sent. byte_cnt=18.
- desc_len=16, req_len=64: two 8-byte packets, then a zlp_set pulse, then done only after a 3rd in_sent.
- desc_len=40, req_len=16: exactly 16 bytes in 2 packets, no ZLP (xfer_len == req_len), done.
- desc_len=0, req_len=8: no mem_rd and no fifo_wrreq. zlp_set 1 cycle after start. done after in_sent.
- Mid-packet abort during the 5th WR of the first packet: fifo_sclr pulse, busy=0 next cycle, no further mem_rd. A later start restarts cleanly. A start pulse while busy is ignored.
- base_addr=0xFC, desc_len=8: reads 0xFC..0xFF, then 0x00..0x03 (address wrap). A stray in_sent during RD/WR has no effect.
